// File: rtl/imem_dump.sv
// imem_dump: walks the instruction memory test port over addresses 0..DEPTH-1 and streams each word out on a valid/ready channel.
// Define IMEM_DUMP_CHECKSUM_EN to append one trailer word (addr DEPTH) carrying the mod-2^DATA_W sum of all dumped words.
module imem_dump #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] test_addr,
    input  logic [DATA_W-1:0] test_data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int IDX_W = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [IDX_W-1:0] idx;
    logic             start_accept;
    logic             handshake;
    logic             at_last;
    logic             final_xfer;

    assign start_accept = (state == S_IDLE) && start;
    // out_valid is high for the whole of SEND, so the handshake reduces to out_ready there
    assign handshake    = (state == S_SEND) && out_ready;
    assign at_last      = (idx == LAST_IDX);

`ifdef IMEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic              sum_sent;
    logic              load_sum;

    assign load_sum   = handshake && at_last && !sum_sent;
    assign final_xfer = handshake && sum_sent;
`else
    assign final_xfer = handshake && at_last;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_ADDR;
            S_ADDR:    state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_SEND;
            S_SEND: begin
                if (final_xfer)
                    state_next = S_FIN;
                else if (handshake && !at_last)
                    state_next = S_ADDR;
            end
            S_FIN:     state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // test_addr is loaded on entry to ADDR so a registered memory has data ready by the end of CAPTURE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            test_addr <= '0;
        end else if (start_accept) begin
            idx       <= '0;
            test_addr <= '0;
        end else if (handshake && !at_last) begin
            idx       <= idx + 1'b1;
            test_addr <= ADDR_W'(idx + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (state == S_CAPTURE) begin
            out_valid <= 1'b1;
            out_addr  <= ADDR_W'(idx);
            out_data  <= test_data_out;
`ifdef IMEM_DUMP_CHECKSUM_EN
            out_last  <= 1'b0;
        end else if (load_sum) begin
            out_addr  <= ADDR_W'(DEPTH);
            out_data  <= sum;
            out_last  <= 1'b1;
`else
            out_last  <= at_last;
`endif
        end else if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= final_xfer;
            if (start_accept)
                busy <= 1'b1;
            else if (final_xfer)
                busy <= 1'b0;
        end
    end

`ifdef IMEM_DUMP_CHECKSUM_EN
    // The sum already includes the last memory word by the time its handshake loads the trailer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum      <= '0;
            sum_sent <= 1'b0;
        end else if (start_accept) begin
            sum      <= '0;
            sum_sent <= 1'b0;
        end else begin
            if (state == S_CAPTURE)
                sum <= sum + test_data_out;
            if (load_sum)
                sum_sent <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_dump.sv
// tb_imem_dump: directed checks of imem_dump with a 4-word memory and a 256-word memory behind registered read ports.
// Expectations for the trailer word are enabled when IMEM_DUMP_CHECKSUM_EN is defined.
module tb_imem_dump;

    localparam int DEPTH     = 4;
    localparam int BIG_DEPTH = 256;
`ifdef IMEM_DUMP_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] test_addr;
    logic [31:0] test_data_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        out_last;

    logic        big_start;
    logic        big_busy;
    logic        big_done;
    logic [31:0] big_test_addr;
    logic [31:0] big_data_out;
    logic        big_valid;
    logic        big_ready;
    logic [31:0] big_addr;
    logic [31:0] big_data;
    logic        big_last;

    logic [31:0] mem4   [DEPTH];
    logic [31:0] mem256 [BIG_DEPTH];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int big_xfer = 0;
    int big_bad = 0;
    int big_last_addr = -1;
    logic [31:0] big_peak = '0;

    always #5 clk = ~clk;

    imem_dump #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .test_addr(test_addr), .test_data_out(test_data_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
    );

    imem_dump #(.DEPTH(BIG_DEPTH), .ADDR_W(32), .DATA_W(32)) dut_big (
        .clk(clk), .reset(reset), .start(big_start), .busy(big_busy), .done(big_done),
        .test_addr(big_test_addr), .test_data_out(big_data_out),
        .out_valid(big_valid), .out_ready(big_ready),
        .out_addr(big_addr), .out_data(big_data), .out_last(big_last)
    );

    function automatic logic [31:0] big_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {8'hC3, b, ~b, b ^ 8'h5A};
    endfunction

    // Registered read ports: data follows the address by one clock
    always @(posedge clk) begin
        test_data_out <= mem4[test_addr[1:0]];
        big_data_out  <= mem256[big_test_addr[7:0]];
    end

    always @(posedge clk) begin
        edge_cnt++;
        if (reset && out_valid && out_ready) xfer_cnt++;
        if (reset && done) done_cnt++;
        if (reset) begin
            if (big_test_addr > big_peak) big_peak = big_test_addr;
            if (big_valid && big_ready) begin
                if (big_addr !== 32'(big_xfer)) big_bad++;
                if (big_addr < 32'(BIG_DEPTH) && big_data !== big_word(big_addr)) big_bad++;
                if (big_last) big_last_addr = int'(big_addr);
                big_xfer++;
            end
        end
    end

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_valid(input string tag);
        int g = 0;
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check_bit({tag, "_valid_wait"}, out_valid, 1'b1);
    endtask

    task automatic recv_word(input int a, input logic [31:0] d, input logic l);
        wait_valid($sformatf("word%0d", a));
        check_val($sformatf("word%0d_addr", a), out_addr, 32'(a));
        check_val($sformatf("word%0d_data", a), out_data, d);
        check_bit($sformatf("word%0d_last", a), out_last, l);
        @(negedge clk);
    endtask

    task automatic recv_rest(input int first);
        for (int k = first; k < DEPTH; k++)
            recv_word(k, mem4[k], logic'(k == DEPTH - 1 && EXTRA == 0));
`ifdef IMEM_DUMP_CHECKSUM_EN
        recv_word(DEPTH, 32'hAA, 1'b1);
`endif
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (!done && g < 20) begin
            @(negedge clk);
            g++;
        end
        check_bit({tag, "_done"}, done, 1'b1);
        check_bit({tag, "_busy_at_done"}, busy, 1'b0);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the end of the sequence");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int x0;
        int d0;
        int e_start;
        int g;

        mem4[0] = 32'h11;
        mem4[1] = 32'h22;
        mem4[2] = 32'h33;
        mem4[3] = 32'h44;
        for (int i = 0; i < BIG_DEPTH; i++) mem256[i] = big_word(32'(i));

        reset = 1'b0;
        start = 1'b0;
        big_start = 1'b0;
        out_ready = 1'b1;
        big_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] reset values");
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_valid", out_valid, 1'b0);
        check_bit("rst_last", out_last, 1'b0);
        check_val("rst_test_addr", test_addr, 32'h0);
        check_val("rst_out_addr", out_addr, 32'h0);
        check_val("rst_out_data", out_data, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] basic dump");
        x0 = xfer_cnt;
        d0 = done_cnt;
        e_start = edge_cnt;
        start_pulse();
        check_bit("accept_busy", busy, 1'b1);
        check_bit("accept_valid", out_valid, 1'b0);
        check_val("accept_test_addr", test_addr, 32'h0);
        @(negedge clk);
        check_bit("capture_valid", out_valid, 1'b0);
        @(negedge clk);
        check_bit("first_word_valid", out_valid, 1'b1);
        recv_rest(0);
        wait_done("basic");
        // Edges counted inclusively from the one sampling start to the one sampling done
        check_val("basic_done_latency", 32'(edge_cnt + 1 - e_start), 32'(3 * DEPTH + 2 + EXTRA));
        @(negedge clk);
        check_bit("basic_done_pulse", done, 1'b0);
        check_val("basic_xfers", 32'(xfer_cnt - x0), 32'(DEPTH + EXTRA));
        check_val("basic_dones", 32'(done_cnt - d0), 32'd1);

        $display("[TB] backpressure");
        x0 = xfer_cnt;
        d0 = done_cnt;
        start_pulse();
        recv_word(0, mem4[0], 1'b0);
        out_ready = 1'b0;
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            check_bit($sformatf("stall%0d_valid", i), out_valid, 1'b1);
            check_val($sformatf("stall%0d_data", i), out_data, 32'h22);
            check_val($sformatf("stall%0d_addr", i), out_addr, 32'h1);
            check_val($sformatf("stall%0d_test_addr", i), test_addr, 32'h1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        recv_rest(1);
        wait_done("bp");
        @(negedge clk);
        check_val("bp_xfers", 32'(xfer_cnt - x0), 32'(DEPTH + EXTRA));
        check_val("bp_dones", 32'(done_cnt - d0), 32'd1);

        $display("[TB] ignored start");
        x0 = xfer_cnt;
        d0 = done_cnt;
        start_pulse();
        recv_word(0, mem4[0], 1'b0);
        start_pulse();
        recv_rest(1);
        wait_done("ign");
        repeat (3) @(negedge clk);
        check_bit("ign_no_retrigger", busy, 1'b0);
        check_val("ign_xfers", 32'(xfer_cnt - x0), 32'(DEPTH + EXTRA));
        check_val("ign_dones", 32'(done_cnt - d0), 32'd1);

        $display("[TB] mid-dump reset");
        x0 = xfer_cnt;
        d0 = done_cnt;
        start_pulse();
        recv_word(0, mem4[0], 1'b0);
        recv_word(1, mem4[1], 1'b0);
        out_ready = 1'b0;
        wait_valid("pre_reset");
        check_val("pre_reset_addr", out_addr, 32'h2);
        reset = 1'b0;
        #1;
        check_bit("mid_rst_busy", busy, 1'b0);
        check_bit("mid_rst_valid", out_valid, 1'b0);
        check_bit("mid_rst_last", out_last, 1'b0);
        check_val("mid_rst_out_addr", out_addr, 32'h0);
        check_val("mid_rst_out_data", out_data, 32'h0);
        check_val("mid_rst_test_addr", test_addr, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_bit("post_rst_valid", out_valid, 1'b0);
        check_bit("post_rst_busy", busy, 1'b0);
        check_val("post_rst_dones", 32'(done_cnt - d0), 32'd0);
        check_val("post_rst_xfers", 32'(xfer_cnt - x0), 32'd2);
        start_pulse();
        recv_rest(0);
        wait_done("restart");
        @(negedge clk);

        $display("[TB] full depth");
        big_start = 1'b1;
        @(negedge clk);
        big_start = 1'b0;
        g = 0;
        while (!big_done && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check_bit("big_done", big_done, 1'b1);
        @(negedge clk);
        check_val("big_xfers", 32'(big_xfer), 32'(BIG_DEPTH + EXTRA));
        check_val("big_bad_words", 32'(big_bad), 32'd0);
        check_val("big_peak_test_addr", big_peak, 32'(BIG_DEPTH - 1));
        check_val("big_last_addr", 32'(big_last_addr), 32'(BIG_DEPTH - 1 + EXTRA));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_dump.md
# imem_dump

Read-back engine for the instruction memory test port. It walks the test port addresses 0..DEPTH-1, captures each word and streams it out over a valid/ready handshake. The bench or a host link uses it to verify injected code against `test.hex`. It sits beside `instrMem` on the probe side and is the reading counterpart of the bench-side code-injection writer.

## Interface
- `DEPTH`, 256, number of words dumped; minimum 1.
- `ADDR_W`, 32, width of the test port address.
- `DATA_W`, 32, width of the data word.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; begins a dump when the block is idle.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the final word handshakes.
- `test_addr`  out  ADDR_W  address driven to the memory test port.
- `test_data_out`  in  DATA_W  word read from the memory test port.
- `out_valid`  out  1  an output word is presented.
- `out_ready`  in  1  the consumer accepts the word.
- `out_addr`  out  ADDR_W  address of the presented word.
- `out_data`  out  DATA_W  presented word.
- `out_last`  out  1  the presented word is the final word of the dump.

## Operation
- **States:**
  - IDLE: waits for `start`=1, then moves to ADDR.
  - ADDR: drives `test_addr`=idx, moves to CAPTURE.
  - CAPTURE: registers `test_data_out` into `out_data` and idx into `out_addr`, moves to SEND.
  - SEND: holds `out_valid`=1 until `out_ready`=1. On the handshake, goes to ADDR with idx+1, or to FIN after the last word.
  - FIN: pulses `done`, returns to IDLE.
- The idx counter is `$clog2(DEPTH)+1` bits wide and zero-extended onto `test_addr`. It never wraps; the dump ends at DEPTH-1.
- `out_data`, `out_addr` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
- `out_valid` never drops without a handshake.
- `start` is ignored outside IDLE.
- `start` held high in IDLE after `done` begins a new dump; the block re-arms.
- `test_addr` holds its last value outside ADDR and CAPTURE; the memory read is non-destructive.
- Asynchronous reset during a dump aborts immediately. Nothing further is emitted and no `done` pulse is produced.

## Timing
- **Reset values:**
  - `busy`, `done`, `out_valid`, `out_last` = 0.
  - `test_addr`, `out_addr`, `out_data` = 0.
  - State = IDLE, idx = 0.
- **Memory read latency:** `test_data_out` must be valid one cycle after `test_addr` changes. It is sampled at the end of CAPTURE.
- **Latency:** `start` sampled at edge 0 gives `out_valid` at edge 3 (IDLE→ADDR→CAPTURE→SEND).
- **Throughput:** with `out_ready` tied high, one word per 3 cycles, so DEPTH·3 + 2 cycles from `start` to `done`.
- **Handshake:** a transfer occurs on any rising edge with `out_valid`=1 and `out_ready`=1. `out_ready` may be high before `out_valid`.
- `done` is asserted the cycle after the final handshake. `busy` falls in that same cycle.

## Configuration
- **`IMEM_DUMP_CHECKSUM_EN` defined:**
  - The block keeps a running sum mod 2^DATA_W of all dumped words, cleared on `start` acceptance.
  - After word DEPTH-1 it emits one extra SEND word with `out_addr`=DEPTH, `out_data`=sum and `out_last`=1.
  - Word DEPTH-1 is emitted with `out_last`=0.
  - Total transfers: DEPTH+1.
- **Not defined:** no sum logic. Word DEPTH-1 carries `out_last`=1. Total transfers: DEPTH.

## Test plan
- **Basic dump:** DEPTH=4, memory {0x11,0x22,0x33,0x44}, `out_ready`=1, pulse `start` → words (0,0x11),(1,0x22),(2,0x33),(3,0x44); `out_last` on addr 3; `done` at cycle 14 after `start`.
- **Backpressure:** hold `out_ready`=0 for 5 cycles at word 1 → `out_valid` stays 1, `out_data`=0x22 is stable and `test_addr` is unchanged; the remaining words follow with no loss or duplicate.
- **Mid-dump reset:** assert `reset`=0 during SEND of word 2 → every output reads 0 within the same cycle; no `done` pulse. A fresh `start` restarts from addr 0.
- **Ignored start:** pulse `start` during word 1 → exactly DEPTH transfers and one `done`.
- **Checksum:** with `IMEM_DUMP_CHECKSUM_EN`, the basic-dump data → fifth word addr 4, data 0xAA, `out_last`=1; word 3 has `out_last`=0.
- **Full depth:** DEPTH=256 with the memory preloaded from the injected hex → all 256 words match the file, and `test_addr` peaks at 255.
